// File: rtl/seg7_pkg.sv
// Shared constants, state encoding and helpers for the 4-digit 7-segment scan controller.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] DIG_NONE  = 8'h00;

  // Active-low segment patterns, entry n at bits [8n+7:8n]; bit7 (DP) is off in every entry.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4,
    ST_NEXT    = 3'd5
  } scanState_e;

  // Index of the most-significant nonzero nibble; an all-zero value reports digit 0.
  function automatic logic [1:0] topNibble(input logic [15:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (v[i*4 +: 4] != 4'h0) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Bundle between the scan controller, the application registers and the 74HC595 driver.
interface seg7_scan_ctrl_if;

  logic        en_i;
  logic [15:0] value_i;
  logic [3:0]  dp_i;
  logic        drv_busy_i;
  logic [15:0] drv_data_o;
  logic        drv_start_o;
  logic [1:0]  digit_idx_o;
  logic        frame_done_o;

  modport master (
    input  en_i, value_i, dp_i, drv_busy_i,
    output drv_data_o, drv_start_o, digit_idx_o, frame_done_o
  );

  modport slave (
    output en_i, value_i, dp_i, drv_busy_i,
    input  drv_data_o, drv_start_o, digit_idx_o, frame_done_o
  );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low segment decoder; a lit decimal point clears bit7.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SEG_TABLE[nibble_i];
    if (dp_i) seg_o[7] = 1'b0;
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan of a 16-bit hex value over four digits, one frame per slot to the 595 driver.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most-significant nonzero nibble.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int NUM_DIGITS  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  seg7_scan_ctrl_if.master bus
);

  localparam logic [19:0] PresMax   = 20'(REFRESH_DIV - 1);
  localparam logic [1:0]  LastDigit = 2'(NUM_DIGITS - 1);

  scanState_e  state_q;
  logic [19:0] prescaler_q, prescaler_d;
  logic        slotTick;
  logic        tickPend_q;
  logic        blankXfer_q;
  logic        lit_q;
  logic [1:0]  waitCnt_q;
  logic [1:0]  digitIdx_q;
  logic [15:0] snapValue_q;
  logic [3:0]  snapDp_q;
  logic [15:0] drvData_q;
  logic        drvStart_q;
  logic        frameDone_q;

  logic [15:0] srcValue;
  logic [3:0]  srcDp;
  logic [3:0]  nibble;
  logic        digitDp;
  logic        blankDigit;
  logic [7:0]  decSeg;
  logic [7:0]  frameSeg;
  logic [7:0]  frameDig;

  always_comb begin
    slotTick    = bus.en_i && (prescaler_q == PresMax);
    prescaler_d = prescaler_q + 20'd1;
    if (!bus.en_i || slotTick) prescaler_d = 20'd0;
  end

  // Digit 0 decodes straight from the live inputs because the snapshot is taken in that same LOAD.
  always_comb begin
    srcValue = (digitIdx_q == 2'd0) ? bus.value_i : snapValue_q;
    srcDp    = (digitIdx_q == 2'd0) ? bus.dp_i    : snapDp_q;
    nibble   = srcValue[{digitIdx_q, 2'b00} +: 4];
    digitDp  = srcDp[digitIdx_q];
`ifdef LEADING_ZERO_BLANK_EN
    blankDigit = (digitIdx_q > topNibble(srcValue)) && !digitDp;
`else
    blankDigit = 1'b0;
`endif
    frameSeg = blankDigit ? SEG_BLANK : decSeg;
    frameDig = 8'h01 << digitIdx_q;
  end

  hex_to_seg7 u_dec (
    .nibble_i (nibble),
    .dp_i     (digitDp),
    .seg_o    (decSeg)
  );

  // lit_q remembers that a digit is on the display, so disabling sends exactly one blank frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      prescaler_q <= 20'd0;
      tickPend_q  <= 1'b0;
      blankXfer_q <= 1'b0;
      lit_q       <= 1'b0;
      waitCnt_q   <= 2'd0;
      digitIdx_q  <= 2'd0;
      snapValue_q <= 16'h0000;
      snapDp_q    <= 4'h0;
      drvData_q   <= 16'h0000;
      drvStart_q  <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      drvStart_q  <= 1'b0;
      frameDone_q <= 1'b0;
      if (!bus.en_i)    tickPend_q <= 1'b0;
      else if (slotTick) tickPend_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (!bus.en_i && lit_q) begin
            blankXfer_q <= 1'b1;
            state_q     <= ST_LOAD;
          end else if (bus.en_i && tickPend_q) begin
            blankXfer_q <= 1'b0;
            tickPend_q  <= 1'b0;
            state_q     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (blankXfer_q) begin
            drvData_q <= {SEG_BLANK, DIG_NONE};
            lit_q     <= 1'b0;
          end else begin
            drvData_q <= {frameSeg, frameDig};
            lit_q     <= 1'b1;
            if (digitIdx_q == 2'd0) begin
              snapValue_q <= bus.value_i;
              snapDp_q    <= bus.dp_i;
            end
          end
          drvStart_q <= 1'b1;
          state_q    <= ST_START;
        end
        ST_START: begin
          waitCnt_q <= 2'd0;
          state_q   <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (bus.drv_busy_i || waitCnt_q == 2'd3) state_q <= ST_WAIT_LO;
          else waitCnt_q <= waitCnt_q + 2'd1;
        end
        ST_WAIT_LO: begin
          if (!bus.drv_busy_i) state_q <= ST_NEXT;
        end
        ST_NEXT: begin
          if (!blankXfer_q && digitIdx_q == LastDigit) frameDone_q <= 1'b1;
          if (blankXfer_q || !bus.en_i) digitIdx_q <= 2'd0;
          else digitIdx_q <= digitIdx_q + 2'd1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.drv_data_o   = drvData_q;
  assign bus.drv_start_o  = drvStart_q;
  assign bus.digit_idx_o  = digitIdx_q;
  assign bus.frame_done_o = frameDone_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with a behavioural 595 driver and a frame scoreboard.
// Build with LEADING_ZERO_BLANK_EN defined to expect blanked leading digits.
module tb_seg7_scan_ctrl;

  localparam int Div = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_ctrl_if bus ();

  seg7_scan_ctrl #(.REFRESH_DIV(Div), .NUM_DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] expQ[$];
  logic [15:0] obsQ[$];
  int gapQ[$];
  int busyLen = 20;
  int busyCnt = 0;
  int cyc = 0;
  int lastFall = 0;
  int startWhileBusy = 0;
  int frameDoneCnt = 0;

  // Driver model: busy rises on the cycle after a start and stays up busyLen cycles (0 = never busy).
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busyCnt        = 0;
      bus.drv_busy_i = 1'b0;
    end else begin
      cyc++;
      if (bus.frame_done_o) frameDoneCnt++;
      if (bus.drv_start_o) begin
        if (bus.drv_busy_i) startWhileBusy++;
        obsQ.push_back(bus.drv_data_o);
        gapQ.push_back(cyc - lastFall);
        if (busyLen > 0) begin
          busyCnt        = busyLen;
          bus.drv_busy_i = 1'b1;
        end
      end else if (busyCnt > 0) begin
        busyCnt--;
        if (busyCnt == 0) begin
          bus.drv_busy_i = 1'b0;
          lastFall       = cyc;
        end
      end
    end
  end

  task automatic doReset(input int len);
    bus.en_i    = 1'b0;
    bus.value_i = 16'h0000;
    bus.dp_i    = 4'h0;
    busyLen     = len;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    obsQ.delete();
    expQ.delete();
    gapQ.delete();
    frameDoneCnt   = 0;
    startWhileBusy = 0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic waitObs(input int n, input int budget, output bit ok);
    int c = 0;
    while (obsQ.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = (obsQ.size() >= n);
  endtask

  task automatic pushFrames(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
    expQ.push_back(a);
    expQ.push_back(b);
    expQ.push_back(c);
    expQ.push_back(d);
  endtask

  // Drop enable, expect the trailing blank frame, then idle long enough to expose any stray start.
  task automatic finishScan(input int total, output bit ok);
    bus.en_i = 1'b0;
    expQ.push_back(16'hFF00);
    waitObs(total, 400, ok);
    repeat (80) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d);
    bus.value_i = v;
    bus.dp_i    = d;
    bus.en_i    = 1'b1;
  endtask

  task automatic test_reset();
    doReset(20);
    checks++;
    if (bus.drv_data_o !== 16'h0000 || bus.drv_start_o !== 1'b0 ||
        bus.digit_idx_o !== 2'd0 || bus.frame_done_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got data=%h start=%b idx=%0d done=%b, want 0000/0/0/0",
               bus.drv_data_o, bus.drv_start_o, bus.digit_idx_o, bus.frame_done_o);
    end
    repeat (60) @(negedge clk);
    checks++;
    if (obsQ.size() !== 0) begin
      errors++;
      $display("[TB] FAIL reset_silent: got %0d starts while disabled, want 0", obsQ.size());
    end
  endtask

  task automatic test_scan_1234();
    bit ok;
    logic [15:0] e, g;
    doReset(20);
    pushFrames(16'h9901, 16'hB002, 16'hA404, 16'hF908);
    pushFrames(16'h9901, 16'hB002, 16'hA404, 16'hF908);
    applyStimulus(16'h1234, 4'h0);
    waitObs(8, 2000, ok);
    finishScan(9, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL scan_timeout: got %0d frames, want 9", obsQ.size()); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      if (obsQ.size() == 0) begin errors++; $display("[TB] FAIL scan_frame: got none, want %h", e); end
      else begin
        g = obsQ.pop_front();
        if (g !== e) begin errors++; $display("[TB] FAIL scan_frame: got %h, want %h", g, e); end
      end
    end
    checks++;
    if (obsQ.size() !== 0) begin errors++; $display("[TB] FAIL scan_extra: got %0d extra starts, want 0", obsQ.size()); end
    checks++;
    if (frameDoneCnt !== 2) begin errors++; $display("[TB] FAIL scan_frame_done: got %0d pulses, want 2", frameDoneCnt); end
    checks++;
    if (bus.digit_idx_o !== 2'd0) begin errors++; $display("[TB] FAIL scan_idx_after_disable: got %0d, want 0", bus.digit_idx_o); end
    checks++;
    if (startWhileBusy !== 0) begin errors++; $display("[TB] FAIL scan_start_busy: got %0d, want 0", startWhileBusy); end
  endtask

  task automatic test_dp_abcd();
    bit ok;
    logic [15:0] e, g;
    doReset(20);
    pushFrames(16'hA101, 16'h4602, 16'h8304, 16'h8808);
    applyStimulus(16'hABCD, 4'b0010);
    waitObs(4, 1000, ok);
    finishScan(5, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL dp_timeout: got %0d frames, want 5", obsQ.size()); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      if (obsQ.size() == 0) begin errors++; $display("[TB] FAIL dp_frame: got none, want %h", e); end
      else begin
        g = obsQ.pop_front();
        if (g !== e) begin errors++; $display("[TB] FAIL dp_frame: got %h, want %h", g, e); end
      end
    end
  endtask

  task automatic test_snapshot();
    bit ok;
    logic [15:0] e, g;
    doReset(20);
    pushFrames(16'hF901, 16'hF902, 16'hF904, 16'hF908);
    pushFrames(16'hA401, 16'hA402, 16'hA404, 16'hA408);
    applyStimulus(16'h1111, 4'h0);
    waitObs(3, 1000, ok);
    bus.value_i = 16'h2222;
    waitObs(8, 1000, ok);
    finishScan(9, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL snap_timeout: got %0d frames, want 9", obsQ.size()); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      if (obsQ.size() == 0) begin errors++; $display("[TB] FAIL snap_frame: got none, want %h", e); end
      else begin
        g = obsQ.pop_front();
        if (g !== e) begin errors++; $display("[TB] FAIL snap_frame: got %h, want %h", g, e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [15:0] e, g;
    doReset(40);
    pushFrames(16'h9901, 16'hB002, 16'hA404, 16'hF908);
    applyStimulus(16'h1234, 4'h0);
    waitObs(4, 1000, ok);
    finishScan(5, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL b2b_timeout: got %0d frames, want 5", obsQ.size()); end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (gapQ.size() <= i) begin errors++; $display("[TB] FAIL b2b_gap: frame %0d missing", i); end
      else if (gapQ[i] < 1 || gapQ[i] > 4) begin
        errors++;
        $display("[TB] FAIL b2b_gap: frame %0d started %0d cycles after busy fell, want 1..4", i, gapQ[i]);
      end
    end
    checks++;
    if (startWhileBusy !== 0) begin errors++; $display("[TB] FAIL b2b_start_busy: got %0d, want 0", startWhileBusy); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      if (obsQ.size() == 0) begin errors++; $display("[TB] FAIL b2b_frame: got none, want %h", e); end
      else begin
        g = obsQ.pop_front();
        if (g !== e) begin errors++; $display("[TB] FAIL b2b_frame: got %h, want %h", g, e); end
      end
    end
    checks++;
    if (obsQ.size() !== 0) begin errors++; $display("[TB] FAIL b2b_extra: got %0d extra starts, want 0", obsQ.size()); end
  endtask

  task automatic test_busy_timeout();
    bit ok;
    logic [15:0] e, g;
    doReset(0);
    pushFrames(16'h8001, 16'hF802, 16'h8204, 16'h9208);
    applyStimulus(16'h5678, 4'h0);
    waitObs(4, 1000, ok);
    finishScan(5, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL timeout_guard: got %0d frames, want 5", obsQ.size()); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      if (obsQ.size() == 0) begin errors++; $display("[TB] FAIL timeout_frame: got none, want %h", e); end
      else begin
        g = obsQ.pop_front();
        if (g !== e) begin errors++; $display("[TB] FAIL timeout_frame: got %h, want %h", g, e); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [15:0] e, g;
    doReset(20);
    applyStimulus(16'h1234, 4'h0);
    waitObs(2, 1000, ok);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.drv_data_o !== 16'h0000 || bus.drv_start_o !== 1'b0 ||
        bus.digit_idx_o !== 2'd0 || bus.frame_done_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: got data=%h start=%b idx=%0d done=%b, want 0000/0/0/0",
               bus.drv_data_o, bus.drv_start_o, bus.digit_idx_o, bus.frame_done_o);
    end
    obsQ.delete();
    gapQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    expQ.push_back(16'h9901);
    waitObs(1, 500, ok);
    finishScan(2, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL reset_restart: got %0d frames, want 2", obsQ.size()); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      if (obsQ.size() == 0) begin errors++; $display("[TB] FAIL reset_frame: got none, want %h", e); end
      else begin
        g = obsQ.pop_front();
        if (g !== e) begin errors++; $display("[TB] FAIL reset_frame: got %h, want %h", g, e); end
      end
    end
  endtask

  task automatic test_leading_zero();
    bit ok;
    logic [15:0] e, g;
    doReset(20);
`ifdef LEADING_ZERO_BLANK_EN
    pushFrames(16'hA401, 16'h9902, 16'hFF04, 16'hFF08);
    pushFrames(16'hC001, 16'hFF02, 16'hFF04, 16'hFF08);
`else
    pushFrames(16'hA401, 16'h9902, 16'hC004, 16'hC008);
    pushFrames(16'hC001, 16'hC002, 16'hC004, 16'hC008);
`endif
    applyStimulus(16'h0042, 4'h0);
    waitObs(2, 1000, ok);
    bus.value_i = 16'h0000;
    waitObs(8, 1000, ok);
    finishScan(9, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL lzb_timeout: got %0d frames, want 9", obsQ.size()); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      if (obsQ.size() == 0) begin errors++; $display("[TB] FAIL lzb_frame: got none, want %h", e); end
      else begin
        g = obsQ.pop_front();
        if (g !== e) begin errors++; $display("[TB] FAIL lzb_frame: got %h, want %h", g, e); end
      end
    end
  endtask

  initial begin
    bus.en_i    = 1'b0;
    bus.value_i = 16'h0000;
    bus.dp_i    = 4'h0;
    test_reset();
    test_scan_1234();
    test_dp_abcd();
    test_snapshot();
    test_back_to_back();
    test_busy_timeout();
    test_reset_mid();
    test_leading_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
